// File: rtl/icache_l1_controller.sv
// Direct-mapped L1 instruction cache controller: owns the tag/valid store and
// sequences the external L1 array for hits, line refills and flushes.
module icache_l1_controller #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int INDEX_BITS  = 5,
  parameter int OFFSET_BITS = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cpu_req,
  input  logic [ADDR_WIDTH-1:0]             cpu_addr,
  output logic                              cpu_ready,
  output logic                              cpu_valid,
  output logic [DATA_WIDTH-1:0]             cpu_data,
  input  logic                              flush,
  output logic                              mem_req,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic                              mem_ack,
  input  logic                              mem_rvalid,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic                              arr_mode,
  output logic [INDEX_BITS+OFFSET_BITS-1:0] arr_addr,
  output logic [DATA_WIDTH-1:0]             arr_wdata,
  input  logic [DATA_WIDTH-1:0]             arr_rdata,
  output logic                              busy,
  output logic [15:0]                       miss_count
);
  localparam int TagBits = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int Lines   = 1 << INDEX_BITS;

  typedef enum logic [2:0] {IDLE, COMPARE, MISS_REQ, FILL, RESPOND, FLUSH} state_t;

  state_t                 state, nextState;
  logic [TagBits-1:0]     tagQ;
  logic [INDEX_BITS-1:0]  indexQ;
  logic [OFFSET_BITS-1:0] offsetQ;
  logic [OFFSET_BITS-1:0] beat;
  logic [Lines-1:0]       validBits;
  logic [TagBits-1:0]     tagStore [Lines];
  logic                   flushPending;
  logic [INDEX_BITS-1:0]  flushIdx;
  logic [15:0]            missCount;
  logic                   accept;
  logic                   hit;
  logic                   lastBeat;

  assign cpu_ready  = (state == IDLE) && !flushPending && !flush;
  assign accept     = cpu_req && cpu_ready;
  assign hit        = validBits[indexQ] && (tagStore[indexQ] == tagQ);
  assign lastBeat   = (state == FILL) && mem_rvalid && (beat == '1);
  assign busy       = (state != IDLE);
  assign miss_count = missCount;

  // NOTE: every output and nextState gets a default first so no path can infer a latch.
  always_comb begin
    nextState = state;
    cpu_valid = 1'b0;
    cpu_data  = '0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    arr_mode  = 1'b0;
    arr_addr  = {indexQ, offsetQ};
    arr_wdata = '0;
    unique case (state)
      IDLE: begin
        if (flush || flushPending) nextState = FLUSH;
        else if (accept)           nextState = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          cpu_valid = 1'b1;
          cpu_data  = arr_rdata;
          nextState = IDLE;
        end else begin
          nextState = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {tagQ, indexQ, {OFFSET_BITS{1'b0}}};
        if (mem_ack) nextState = FILL;
      end
      FILL: begin
        arr_addr = {indexQ, beat};
        if (mem_rvalid) begin
          arr_mode  = 1'b1;
          arr_wdata = mem_rdata;
          if (beat == '1) nextState = RESPOND;
        end
      end
      RESPOND: begin
        cpu_valid = 1'b1;
        cpu_data  = arr_rdata;
        nextState = IDLE;
      end
      FLUSH: begin
        if (flushIdx == '1) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      tagQ         <= '0;
      indexQ       <= '0;
      offsetQ      <= '0;
      beat         <= '0;
      validBits    <= '0;
      flushPending <= 1'b0;
      flushIdx     <= '0;
      missCount    <= '0;
    end else begin
      state <= nextState;
      if (accept) {tagQ, indexQ, offsetQ} <= cpu_addr;
      if (state == MISS_REQ && mem_ack) begin
        beat <= '0;
        if (missCount != 16'hFFFF) missCount <= missCount + 16'd1;
      end
      if (state == FILL && mem_rvalid) beat <= beat + 1'b1;
      if (lastBeat) validBits[indexQ] <= 1'b1;
      // flushIdx wraps back to 0 after the last line, ready for the next flush.
      if (state == FLUSH) begin
        validBits[flushIdx] <= 1'b0;
        flushIdx            <= flushIdx + 1'b1;
      end
      if (state == FLUSH)                      flushPending <= 1'b0;
      else if (flush && state != IDLE)         flushPending <= 1'b1;
    end
  end

  // NOTE: the tag store has no reset; an entry is only read when its valid bit is set.
  always_ff @(posedge clk) begin
    if (lastBeat) tagStore[indexQ] <= tagQ;
  end

endmodule

// File: tb/tb_icache_l1_controller.sv
// Directed self-checking bench for icache_l1_controller with a behavioural
// L1 array and a scripted next-level memory.
module tb_icache_l1_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        cpu_ready;
  logic        cpu_valid;
  logic [15:0] cpu_data;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        arr_mode;
  logic [6:0]  arr_addr;
  logic [15:0] arr_wdata;
  logic [15:0] arr_rdata;
  logic        busy;
  logic [15:0] miss_count;

  int testsRun  = 0;
  int testsFail = 0;
  int writeCount = 0;
  logic [15:0] arrMem [0:127];

  icache_l1_controller dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .cpu_valid(cpu_valid), .cpu_data(cpu_data), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .arr_mode(arr_mode), .arr_addr(arr_addr), .arr_wdata(arr_wdata),
    .arr_rdata(arr_rdata), .busy(busy), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  assign arr_rdata = arrMem[arr_addr];
  always @(posedge clk) begin
    if (arr_mode) begin
      arrMem[arr_addr] <= arr_wdata;
      writeCount <= writeCount + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one request from the cycle after its accept edge until cpu_valid.
  task automatic runFetch(input int ackWait, input logic [15:0] base,
                          input int flushAtBeat, input int resetAtBeat,
                          output logic [15:0] data, output int lat,
                          output bit sawReq, output logic [15:0] reqAddr);
    int  waitCnt = 0;
    int  beats   = 0;
    bit  acked   = 0;
    bit  done    = 0;
    data = '0; lat = -1; sawReq = 0; reqAddr = '0;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      mem_ack = 0; mem_rvalid = 0; flush = 0;
      if (resetAtBeat >= 0 && acked && beats == resetAtBeat) begin
        reset = 1'b0;
        #1;
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_cpu_valid", 32'(cpu_valid), 0);
        check("rst_busy", 32'(busy), 0);
        done = 1;
      end else begin
        if (mem_req) begin
          sawReq = 1; reqAddr = mem_addr;
          if (waitCnt == ackWait) begin mem_ack = 1; acked = 1; end
          else waitCnt++;
        end else if (acked && beats < 4) begin
          mem_rvalid = 1;
          mem_rdata  = base + 16'(beats);
          if (beats == flushAtBeat) flush = 1;
          beats++;
        end
        @(negedge clk);
        if (cpu_valid) begin data = cpu_data; lat = cyc; done = 1; end
        @(posedge clk); #1;
      end
    end
    mem_ack = 0; mem_rvalid = 0; flush = 0;
    if (!done) check("fetch_timeout", 0, 1);
  endtask

  task automatic doFetch(input logic [15:0] addr, input int ackWait, input logic [15:0] base,
                         input int flushAtBeat, input int resetAtBeat,
                         output logic [15:0] data, output int lat,
                         output bit sawReq, output logic [15:0] reqAddr);
    bit ok = 0;
    @(posedge clk); #1;
    cpu_addr = addr; cpu_req = 1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cpu_ready) ok = 1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    cpu_req = 0;
    if (!ok) begin
      check("accept_timeout", 0, 1);
      data = '0; lat = -1; sawReq = 0; reqAddr = '0;
    end else begin
      runFetch(ackWait, base, flushAtBeat, resetAtBeat, data, lat, sawReq, reqAddr);
    end
  endtask

  // Counts consecutive busy cycles that follow; reports whether ready or mem_req showed up.
  task automatic countBusy(output int n, output bit readySeen, output bit reqSeen);
    n = 0; readySeen = 0; reqSeen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (cpu_ready) readySeen = 1;
      if (mem_req)   reqSeen = 1;
    end
  endtask

  logic [15:0] data, reqAddr;
  int          lat, w0, nBusy;
  bit          sawReq, readySeen, reqSeen;

  initial begin
    reset = 0; cpu_req = 0; cpu_addr = '0; flush = 0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_cpu_valid", 32'(cpu_valid), 0);
    check("reset_mem_req", 32'(mem_req), 0);
    check("reset_arr_mode", 32'(arr_mode), 0);
    check("reset_mem_addr", 32'(mem_addr), 0);
    check("reset_cpu_data", 32'(cpu_data), 0);
    check("reset_miss_count", 32'(miss_count), 0);
    @(negedge clk); reset = 1;
    #1;
    check("reset_ready", 32'(cpu_ready), 1);
    check("reset_busy", 32'(busy), 0);

    // Cold miss: tag 2, index 8, offset 3 -> array words 0x20..0x23.
    w0 = writeCount;
    doFetch(16'h0123, 2, 16'hA000, -1, -1, data, lat, sawReq, reqAddr);
    check("cold_mem_addr", 32'(reqAddr), 32'h0120);
    check("cold_data", 32'(data), 32'hA003);
    check("cold_latency", 32'(lat), 9);
    check("cold_writes", 32'(writeCount - w0), 4);
    for (int i = 0; i < 4; i++) check("cold_array", 32'(arrMem[7'h20 + 7'(i)]), 32'hA000 + 32'(i));
    check("cold_miss_count", 32'(miss_count), 1);

    // Hit on the same line.
    w0 = writeCount;
    doFetch(16'h0121, 0, 16'h0000, -1, -1, data, lat, sawReq, reqAddr);
    check("hit_latency", 32'(lat), 1);
    check("hit_data", 32'(data), 32'hA001);
    check("hit_no_mem_req", 32'(sawReq), 0);
    check("hit_no_writes", 32'(writeCount - w0), 0);
    check("hit_miss_count", 32'(miss_count), 1);

    // Conflict: tag 6 evicts tag 2 at index 8, then tag 2 misses again.
    doFetch(16'h0321, 1, 16'hB000, -1, -1, data, lat, sawReq, reqAddr);
    check("conf_mem_addr", 32'(reqAddr), 32'h0320);
    check("conf_data", 32'(data), 32'hB001);
    doFetch(16'h0121, 0, 16'hC000, -1, -1, data, lat, sawReq, reqAddr);
    check("conf_remiss", 32'(sawReq), 1);
    check("conf_remiss_data", 32'(data), 32'hC001);
    check("conf_miss_count", 32'(miss_count), 3);

    // Flush pulsed during a fill: request finishes, then 32 flush cycles.
    doFetch(16'h0200, 0, 16'hD000, 2, -1, data, lat, sawReq, reqAddr);
    check("flushfill_data", 32'(data), 32'hD000);
    check("flushfill_latency", 32'(lat), 7);
    @(negedge clk);
    check("flushfill_ready_blocked", 32'(cpu_ready), 0);
    countBusy(nBusy, readySeen, reqSeen);
    check("flushfill_cycles", 32'(nBusy), 32);
    check("flushfill_ready_low", 32'(readySeen), 0);
    doFetch(16'h0121, 0, 16'hC100, -1, -1, data, lat, sawReq, reqAddr);
    check("flushfill_refetch_miss", 32'(sawReq), 1);
    check("flushfill_miss_count", 32'(miss_count), 5);

    // Reset after two fill beats, then stray rvalid while idle.
    doFetch(16'h0400, 0, 16'hE000, -1, 2, data, lat, sawReq, reqAddr);
    @(negedge clk); reset = 1;
    #1;
    check("rstfill_ready", 32'(cpu_ready), 1);
    check("rstfill_miss_count", 32'(miss_count), 0);
    w0 = writeCount;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mem_rvalid = 1; mem_rdata = 16'hDEAD;
      @(negedge clk);
      check("stray_arr_mode", 32'(arr_mode), 0);
    end
    @(posedge clk); #1; mem_rvalid = 0;
    check("stray_writes", 32'(writeCount - w0), 0);
    doFetch(16'h0121, 0, 16'hC200, -1, -1, data, lat, sawReq, reqAddr);
    check("rstfill_refetch_miss", 32'(sawReq), 1);
    check("rstfill_refetch_data", 32'(data), 32'hC201);

    // Flush and request in the same idle cycle: flush wins, request waits.
    @(posedge clk); #1;
    flush = 1; cpu_req = 1; cpu_addr = 16'h0121;
    @(negedge clk);
    check("simul_ready", 32'(cpu_ready), 0);
    @(posedge clk); #1;
    flush = 0;
    countBusy(nBusy, readySeen, reqSeen);
    check("simul_flush_cycles", 32'(nBusy), 32);
    check("simul_no_mem_req", 32'(reqSeen), 0);
    check("simul_ready_after", 32'(cpu_ready), 1);
    @(posedge clk); #1;
    cpu_req = 0;
    runFetch(0, 16'hF000, -1, -1, data, lat, sawReq, reqAddr);
    check("simul_miss", 32'(sawReq), 1);
    check("simul_data", 32'(data), 32'hF001);
    check("simul_latency", 32'(lat), 7);
    check("simul_miss_count", 32'(miss_count), 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
